// File: rtl/h14tx_pkg.sv
// h14tx_pkg: shared types and constants for the HDMI 1.4 TMDS lane encoder.
package h14tx_pkg;

   localparam int DisparityWidth = 5;

   typedef enum logic [2:0] {
      PerControl     = 3'd0,
      PerVideoGuard  = 3'd1,
      PerVideoActive = 3'd2,
      PerDataGuard   = 3'd3,
      PerDataIsland  = 3'd4
   } period_t;

   // Symbols are written q_out[9:0]; bit 0 leaves the serialiser first.
   localparam logic [9:0] CtlCode00   = 10'b1101010100;
   localparam logic [9:0] CtlCode01   = 10'b0010101011;
   localparam logic [9:0] CtlCode10   = 10'b0101010100;
   localparam logic [9:0] CtlCode11   = 10'b1010101011;
   localparam logic [9:0] VideoGuardA = 10'b1011001100;
   localparam logic [9:0] VideoGuardB = 10'b0100110011;

   function automatic logic [9:0] ctl_code(input logic [1:0] ctl);
      logic [9:0] code;
      case (ctl)
         2'b00:   code = CtlCode00;
         2'b01:   code = CtlCode01;
         2'b10:   code = CtlCode10;
         default: code = CtlCode11;
      endcase
      return code;
   endfunction

   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/h14tx_terc4.sv
// h14tx_terc4: combinational TERC4 nibble-to-symbol table (HDMI 1.4).
module h14tx_terc4 (
   input  logic [3:0] nib_i,
   output logic [9:0] sym_o
);

   // Straight table lookup; the caller registers the result.
   always_comb begin
      case (nib_i)
         4'h0:    sym_o = 10'b1010011100;
         4'h1:    sym_o = 10'b1001100011;
         4'h2:    sym_o = 10'b1011100100;
         4'h3:    sym_o = 10'b1011100010;
         4'h4:    sym_o = 10'b0101110001;
         4'h5:    sym_o = 10'b0100011110;
         4'h6:    sym_o = 10'b0110001110;
         4'h7:    sym_o = 10'b0100111100;
         4'h8:    sym_o = 10'b1011001100;
         4'h9:    sym_o = 10'b0100111001;
         4'hA:    sym_o = 10'b0110011100;
         4'hB:    sym_o = 10'b1011000110;
         4'hC:    sym_o = 10'b1010001110;
         4'hD:    sym_o = 10'b1001110001;
         4'hE:    sym_o = 10'b0101100011;
         default: sym_o = 10'b1011000011;
      endcase
   end

endmodule

// File: rtl/h14tx_lane.sv
// h14tx_lane: one HDMI 1.4 TMDS channel encoder (control, video guard,
// DVI 8b/10b video, TERC4 data island / data guard) with an optional
// period-sequence checker. Two-stage pipeline, 2-cycle latency on every path.
// Build option: H14TX_DATA_ISLAND_EN enables TERC4 data-island support;
// without it, DataIsland/DataGuard encode as Control and are flagged.
module h14tx_lane
   import h14tx_pkg::*;
#(
   parameter int Chan     = 0,
   parameter bit SeqCheck = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  period_t                   period_i,
   input  logic [1:0]                ctl_i,
   input  logic [7:0]                video_i,
   input  logic [3:0]                aux_i,
   output logic [9:0]                symbol_o,
   output logic [DisparityWidth-1:0] disparity_o,
   output logic                      seq_err_o
);

   if (Chan < 0 || Chan > 2) begin : g_bad_chan
      $error("h14tx_lane: Chan must be 0, 1 or 2");
   end

   period_t                   period_s1_q;
   logic [1:0]                ctl_s1_q;
   logic [8:0]                qm_s1_q;
   logic [8:0]                qm_d;
   logic [3:0]                n1_vid;
   logic                      use_xnor;

   logic [9:0]                symbol_q;
   logic [9:0]                sym_d;
   logic [DisparityWidth-1:0] disp_q;
   logic [DisparityWidth-1:0] disp_d;
   logic [DisparityWidth-1:0] diff;
   logic [3:0]                n1_qm;
   logic                      qm8;

   // Stage 1 combinational: transition-minimising q_m from the raw pixel.
   always_comb begin
      qm_d     = '0;
      n1_vid   = ones8(video_i);
      use_xnor = (n1_vid > 4'd4) || ((n1_vid == 4'd4) && !video_i[0]);
      qm_d[0]  = video_i[0];
      for (int i = 1; i < 8; i++) begin
         qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ video_i[i]) : (qm_d[i-1] ^ video_i[i]);
      end
      qm_d[8] = ~use_xnor;
   end

`ifdef H14TX_DATA_ISLAND_EN
   logic [3:0] aux_s1_q;
   logic [3:0] nib_d;
   logic [9:0] terc4_sym;

   // Channel 0 carries hsync/vsync in the low TERC4 bits during islands and guards.
   always_comb begin
      nib_d = aux_s1_q;
      if (Chan == 0) begin
         if (period_s1_q == PerDataGuard) begin
            nib_d = {2'b11, ctl_s1_q};
         end else begin
            nib_d = {aux_s1_q[3:2], ctl_s1_q};
         end
      end
   end

   h14tx_terc4 u_terc4 (
      .nib_i (nib_d),
      .sym_o (terc4_sym)
   );

   // Stage 1 register for the auxiliary nibble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aux_s1_q <= '0;
      end else begin
         aux_s1_q <= aux_i;
      end
   end
`else
   logic unused_aux;
   assign unused_aux = ^aux_i;
`endif

   // Stage 1 registers: period, control bits and q_m.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         period_s1_q <= PerControl;
         ctl_s1_q    <= '0;
         qm_s1_q     <= '0;
      end else begin
         period_s1_q <= period_i;
         ctl_s1_q    <= ctl_i;
         qm_s1_q     <= qm_d;
      end
   end

   // Stage 2 combinational: symbol select and DVI DC balancing.
   always_comb begin
      sym_d  = ctl_code(ctl_s1_q);
      disp_d = '0;
      qm8    = qm_s1_q[8];
      n1_qm  = ones8(qm_s1_q[7:0]);
      // n1 - n0 = 2*n1 - 8, in the same modular width as the disparity.
      diff   = DisparityWidth'({n1_qm, 1'b0}) - DisparityWidth'(8);
      case (period_s1_q)
         PerVideoGuard: begin
            sym_d = (Chan == 1) ? VideoGuardB : VideoGuardA;
         end
         PerVideoActive: begin
            if ((disp_q == '0) || (n1_qm == 4'd4)) begin
               sym_d  = {~qm8, qm8, (qm8 ? qm_s1_q[7:0] : ~qm_s1_q[7:0])};
               disp_d = qm8 ? (disp_q + diff) : (disp_q - diff);
            end else if ((!disp_q[DisparityWidth-1] && (n1_qm > 4'd4)) ||
                         (disp_q[DisparityWidth-1] && (n1_qm < 4'd4))) begin
               sym_d  = {1'b1, qm8, ~qm_s1_q[7:0]};
               disp_d = disp_q + DisparityWidth'({qm8, 1'b0}) - diff;
            end else begin
               sym_d  = {1'b0, qm8, qm_s1_q[7:0]};
               disp_d = disp_q - DisparityWidth'({~qm8, 1'b0}) + diff;
            end
         end
`ifdef H14TX_DATA_ISLAND_EN
         PerDataGuard: begin
            sym_d = (Chan == 0) ? terc4_sym : VideoGuardB;
         end
         PerDataIsland: begin
            sym_d = terc4_sym;
         end
`endif
         default: ;
      endcase
   end

   // Stage 2 registers; disparity is zero whenever this stage is not video.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         symbol_q <= CtlCode00;
         disp_q   <= '0;
      end else begin
         symbol_q <= sym_d;
         disp_q   <= disp_d;
      end
   end

   assign symbol_o    = symbol_q;
   assign disparity_o = disp_q;

   if (SeqCheck) begin : g_seq
      period_t    prev_q;
      logic [1:0] run_q;
      logic [1:0] run_d;
      logic       err_q;
      logic       viol;
      logic       guard_cur;
      logic       guard_prev;
      logic       same;

      assign guard_cur  = (period_s1_q == PerVideoGuard) || (period_s1_q == PerDataGuard);
      assign guard_prev = (prev_q == PerVideoGuard) || (prev_q == PerDataGuard);
      assign same       = (period_s1_q == prev_q);

      // Rule evaluation on the stage-1 period against the one before it.
      always_comb begin
         viol  = 1'b0;
         run_d = 2'd0;
         if (guard_cur) begin
            if (same) begin
               run_d = (run_q == 2'd3) ? 2'd3 : (run_q + 2'd1);
            end else begin
               run_d = 2'd1;
            end
         end
         // Third consecutive guard cycle: flag now, not at the end of the run.
         if (guard_cur && same && (run_q >= 2'd2)) begin
            viol = 1'b1;
         end
         if (guard_prev && !same && (run_q != 2'd2)) begin
            viol = 1'b1;
         end
         // One guard type straight into the other is a bad entry.
         if (guard_cur && guard_prev && !same) begin
            viol = 1'b1;
         end
         if ((period_s1_q == PerVideoActive) && (prev_q != PerVideoActive) &&
             (prev_q != PerVideoGuard)) begin
            viol = 1'b1;
         end
`ifdef H14TX_DATA_ISLAND_EN
         if ((period_s1_q == PerDataIsland) && (prev_q != PerDataIsland) &&
             (prev_q != PerDataGuard)) begin
            viol = 1'b1;
         end
         if ((prev_q == PerDataIsland) && (period_s1_q != PerDataIsland) &&
             (period_s1_q != PerDataGuard)) begin
            viol = 1'b1;
         end
`else
         if ((period_s1_q == PerDataGuard) || (period_s1_q == PerDataIsland)) begin
            viol = 1'b1;
         end
`endif
      end

      // Sticky error, registered alongside the symbol it refers to.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            prev_q <= PerControl;
            run_q  <= 2'd0;
            err_q  <= 1'b0;
         end else begin
            prev_q <= period_s1_q;
            run_q  <= run_d;
            err_q  <= err_q | viol;
         end
      end

      assign seq_err_o = err_q;
   end else begin : g_no_seq
      assign seq_err_o = 1'b0;
   end

endmodule
